upgrade_pickup_mgr: RTL and testbench

- Generalised pickup/upgrade arbiter for the shooter: one on-screen upgrade pickup contested by NUM_PLAYERS ships.
- Detects box overlap per frame and grants the upgrade to exactly one player. The grant lasts a timed duration, then the pickup respawns after a cooldown.
- Sits between the ship motion blocks (positions) and the bullet/draw logic (upgrade flags, pickup visibility).

---
 rtl/upgrade_pkg.sv | 14 +
 rtl/box_hit.sv | 24 ++
 rtl/upgrade_pickup_mgr.sv | 134 +++++++++++++
 tb/tb_upgrade_pickup_mgr.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/upgrade_pkg.sv
// rtl/upgrade_pkg.sv - shared state encoding and frame defaults for the upgrade pickup manager
package upgrade_pkg;

   typedef enum logic [1:0] {
      HIDDEN  = 2'd0,
      ACTIVE  = 2'd1,
      HELD    = 2'd2,
      RESPAWN = 2'd3
   } pickup_state_e;

   localparam int HOLD_FRAMES_DEF    = 600;
   localparam int RESPAWN_FRAMES_DEF = 300;

endpackage

// File: rtl/box_hit.sv
// rtl/box_hit.sv - inclusive box overlap test of one ship centre against the pickup
module box_hit #(
   parameter int COORD_W = 10
) (
   input  logic [COORD_W-1:0] px,
   input  logic [COORD_W-1:0] py,
   input  logic [COORD_W-1:0] cx,
   input  logic [COORD_W-1:0] cy,
   input  logic [COORD_W-1:0] size,
   output logic               hit
);

   logic [COORD_W:0] lo_x, hi_x, lo_y, hi_y;

   // One extra bit so the upper bound never wraps; lower bound clamps at the screen edge.
   assign lo_x = (size > cx) ? '0 : ({1'b0, cx} - {1'b0, size});
   assign lo_y = (size > cy) ? '0 : ({1'b0, cy} - {1'b0, size});
   assign hi_x = {1'b0, cx} + {1'b0, size};
   assign hi_y = {1'b0, cy} + {1'b0, size};

   assign hit = ({1'b0, px} >= lo_x) && ({1'b0, px} <= hi_x) &&
                ({1'b0, py} >= lo_y) && ({1'b0, py} <= hi_y);

endmodule

// File: rtl/upgrade_pickup_mgr.sv
// rtl/upgrade_pickup_mgr.sv - single pickup arbitrated among ships; UPGRADE_TIMEOUT_EN enables timed hold/respawn
module upgrade_pickup_mgr
   import upgrade_pkg::*;
#(
   parameter int NUM_PLAYERS    = 2,
   parameter int COORD_W        = 10,
   parameter int HOLD_FRAMES    = HOLD_FRAMES_DEF,
   parameter int RESPAWN_FRAMES = RESPAWN_FRAMES_DEF,
   parameter int CNT_W          = 10
) (
   input  logic                           frame_clk,
   input  logic                           Reset,
   input  logic                           spawn_en,
   input  logic [NUM_PLAYERS*COORD_W-1:0] player_x,
   input  logic [NUM_PLAYERS*COORD_W-1:0] player_y,
   input  logic [COORD_W-1:0]             pickup_x,
   input  logic [COORD_W-1:0]             pickup_y,
   input  logic [COORD_W-1:0]             pickup_size,
   output logic [NUM_PLAYERS-1:0]         upgraded,
   output logic                           pickup_visible,
   output logic                           was_collected,
   output logic [CNT_W-1:0]               time_left
);

   localparam bit CFG_OK = (HOLD_FRAMES >= 1) && (RESPAWN_FRAMES >= 1) &&
                           (HOLD_FRAMES < 2**CNT_W) && (RESPAWN_FRAMES < 2**CNT_W);

   if (!CFG_OK) begin : g_cfg_err
      $error("upgrade_pickup_mgr: frame counts do not fit CNT_W");
   end

   logic [NUM_PLAYERS-1:0] hits;
   logic [NUM_PLAYERS-1:0] grant;

   for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_hit
      box_hit #(.COORD_W(COORD_W)) u_box_hit (
         .px   (player_x[i*COORD_W +: COORD_W]),
         .py   (player_y[i*COORD_W +: COORD_W]),
         .cx   (pickup_x),
         .cy   (pickup_y),
         .size (pickup_size),
         .hit  (hits[i])
      );
   end

   // Isolate the lowest set bit: lowest-index ship wins, ties never split.
   assign grant = hits & (~hits + NUM_PLAYERS'(1));

   pickup_state_e          state_q, state_d;
   logic [NUM_PLAYERS-1:0] upgraded_q, upgraded_d;
   logic                   collected_q, collected_d;

`ifdef UPGRADE_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign time_left = ((state_q == HELD) || (state_q == RESPAWN)) ? cnt_q : '0;
`else
   assign time_left = '0;
`endif

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= HIDDEN;
         upgraded_q  <= '0;
         collected_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         upgraded_q  <= upgraded_d;
         collected_q <= collected_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      upgraded_d  = upgraded_q;
      collected_d = 1'b0;
`ifdef UPGRADE_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      case (state_q)
         HIDDEN: begin
            if (spawn_en) state_d = ACTIVE;
         end
         ACTIVE: begin
            if (!spawn_en) begin
               state_d = HIDDEN;
            end else if (|hits) begin
               state_d     = HELD;
               upgraded_d  = grant;
               collected_d = 1'b1;
`ifdef UPGRADE_TIMEOUT_EN
               cnt_d       = CNT_W'(HOLD_FRAMES - 1);
`endif
            end
         end
         HELD: begin
`ifdef UPGRADE_TIMEOUT_EN
            if (cnt_q == '0) begin
               state_d    = RESPAWN;
               upgraded_d = '0;
               cnt_d      = CNT_W'(RESPAWN_FRAMES - 1);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
`endif
         end
         RESPAWN: begin
`ifdef UPGRADE_TIMEOUT_EN
            if (cnt_q == '0) begin
               state_d = spawn_en ? ACTIVE : HIDDEN;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
`else
            state_d = HIDDEN;
`endif
         end
         default: state_d = HIDDEN;
      endcase
   end

   assign upgraded       = upgraded_q;
   assign was_collected  = collected_q;
   assign pickup_visible = (state_q == ACTIVE);

endmodule

// File: tb/tb_upgrade_pickup_mgr.sv
// tb/tb_upgrade_pickup_mgr.sv - directed bench with frame-count model for upgrade_pickup_mgr
module tb_upgrade_pickup_mgr;

   localparam int NP   = 2;
   localparam int CW   = 10;
   localparam int HOLD = 600;
   localparam int RESP = 300;
   localparam int TW   = 10;

   logic           frame_clk = 1'b0;
   logic           Reset;
   logic           spawn_en;
   logic [NP*CW-1:0] player_x, player_y;
   logic [CW-1:0]  pickup_x, pickup_y, pickup_size;
   logic [NP-1:0]  upgraded;
   logic           pickup_visible;
   logic           was_collected;
   logic [TW-1:0]  time_left;

   always #5 frame_clk = ~frame_clk;

   upgrade_pickup_mgr #(
      .NUM_PLAYERS(NP), .COORD_W(CW), .HOLD_FRAMES(HOLD),
      .RESPAWN_FRAMES(RESP), .CNT_W(TW)
   ) dut (
      .frame_clk(frame_clk), .Reset(Reset), .spawn_en(spawn_en),
      .player_x(player_x), .player_y(player_y),
      .pickup_x(pickup_x), .pickup_y(pickup_y), .pickup_size(pickup_size),
      .upgraded(upgraded), .pickup_visible(pickup_visible),
      .was_collected(was_collected), .time_left(time_left)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: mode 0 hidden, 1 shown, 2 owned, 3 cooling; timers kept as absolute frame deadlines.
   int m_mode = 0, m_owner = -1, m_until = 0, m_frame = 0;
   bit m_pulse = 0;

   function automatic bit in_box(int p, int c, int s);
      int lo;
      lo = (c - s < 0) ? 0 : c - s;
      return (p >= lo) && (p <= c + s);
   endfunction

   always @(posedge frame_clk or posedge Reset) begin
      int win;
      if (Reset) begin
         m_mode = 0; m_owner = -1; m_pulse = 0; m_until = 0;
      end else begin
         m_frame++;
         m_pulse = 0;
         win = -1;
         for (int i = NP - 1; i >= 0; i--)
            if (in_box(int'(player_x[i*CW +: CW]), int'(pickup_x), int'(pickup_size)) &&
                in_box(int'(player_y[i*CW +: CW]), int'(pickup_y), int'(pickup_size)))
               win = i;
         case (m_mode)
            0: if (spawn_en) m_mode = 1;
            1: if (!spawn_en) m_mode = 0;
               else if (win >= 0) begin
                  m_mode = 2; m_owner = win; m_pulse = 1; m_until = m_frame + HOLD;
               end
`ifdef UPGRADE_TIMEOUT_EN
            2: if (m_frame == m_until) begin
                  m_mode = 3; m_owner = -1; m_until = m_frame + RESP;
               end
            3: if (m_frame == m_until) m_mode = spawn_en ? 1 : 0;
`endif
            default: ;
         endcase
      end
   end

   function automatic int exp_tl();
`ifdef UPGRADE_TIMEOUT_EN
      if (m_mode == 2 || m_mode == 3) return m_until - m_frame - 1;
`endif
      return 0;
   endfunction

   always @(negedge frame_clk) begin
      chk("model_upgraded", int'(upgraded), (m_owner >= 0) ? (1 << m_owner) : 0);
      chk("model_visible", int'(pickup_visible), (m_mode == 1) ? 1 : 0);
      chk("model_collected", int'(was_collected), int'(m_pulse));
      chk("model_time_left", int'(time_left), exp_tl());
   end

   task automatic tick();
      @(posedge frame_clk);
      @(negedge frame_clk);
   endtask

   task automatic place(input int i, input int x, input int y);
      player_x[i*CW +: CW] = CW'(x);
      player_y[i*CW +: CW] = CW'(y);
   endtask

   task automatic reset_pulse();
      #2 Reset = 1'b1;
      tick();
      Reset = 1'b0;
      tick();
   endtask

   int held, hid, guard;

   initial begin
      Reset = 1'b1; spawn_en = 1'b0;
      player_x = '0; player_y = '0;
      pickup_x = 10'd100; pickup_y = 10'd100; pickup_size = 10'd8;
      place(0, 500, 500); place(1, 600, 600);
      #12;
      chk("reset_upgraded", int'(upgraded), 0);
      chk("reset_visible", int'(pickup_visible), 0);
      chk("reset_time_left", int'(time_left), 0);
      spawn_en = 1'b1;
      @(negedge frame_clk);
      Reset = 1'b0;
      chk("hidden_before_edge", int'(pickup_visible), 0);
      tick();
      chk("visible_after_spawn", int'(pickup_visible), 1);
      tick(); tick();
      chk("idle_upgraded", int'(upgraded), 0);

      // Inclusive corner hit for P1.
      place(0, 108, 92);
      tick();
      held = 1;
      chk("grant_p1", int'(upgraded), 1);
      chk("grant_pulse", int'(was_collected), 1);
      chk("grant_hidden", int'(pickup_visible), 0);
`ifdef UPGRADE_TIMEOUT_EN
      chk("grant_time_left", int'(time_left), HOLD - 1);
`else
      chk("grant_time_left", int'(time_left), 0);
`endif
      place(0, 500, 500);
      tick();
      if (upgraded != 0) held++;
      chk("pulse_one_frame", int'(was_collected), 0);
      place(1, 100, 100);
      repeat (5) begin
         tick();
         if (upgraded != 0) held++;
      end
      chk("no_steal", int'(upgraded), 1);
      place(1, 600, 600);
`ifdef UPGRADE_TIMEOUT_EN
      guard = 0;
      while (upgraded != 0 && guard < 800) begin
         tick(); guard++;
         if (upgraded != 0) held++;
      end
      chk("hold_len", held, HOLD);
      hid = 1;
      guard = 0;
      while (!pickup_visible && guard < 500) begin
         tick(); guard++;
         if (!pickup_visible) hid++;
      end
      chk("respawn_len", hid, RESP);
`else
      repeat (2100) tick();
      chk("legacy_latched", int'(upgraded), 1);
      chk("legacy_time_left", int'(time_left), 0);
      reset_pulse();
`endif

      // Simultaneous hit: lowest index only.
      place(0, 100, 100); place(1, 100, 100);
      tick();
      chk("tie_low_wins", int'(upgraded), 1);
      place(0, 500, 500); place(1, 600, 600);
`ifdef UPGRADE_TIMEOUT_EN
      guard = 0;
      while (upgraded != 0 && guard < 800) begin tick(); guard++; end
      repeat (10) tick();
      spawn_en = 1'b0;
      repeat (RESP) tick();
      chk("spawn_off_hidden", int'(pickup_visible), 0);
      spawn_en = 1'b1;
      tick();
      chk("respawn_rearm", int'(pickup_visible), 1);
`else
      repeat (3) tick();
      reset_pulse();
`endif

      // Clamped lower bound near origin; far corner must not hit.
      pickup_x = 10'd3; pickup_y = 10'd3;
      place(0, 1023, 1023); place(1, 0, 0);
      tick();
      chk("clamp_p2", int'(upgraded), 2);
`ifdef UPGRADE_TIMEOUT_EN
      repeat (HOLD - 1 - 250) tick();
      chk("mid_hold_time_left", int'(time_left), 250);
`else
      repeat (10) tick();
`endif
      #2 Reset = 1'b1;
      #1;
      chk("async_upgraded", int'(upgraded), 0);
      chk("async_visible", int'(pickup_visible), 0);
      chk("async_time_left", int'(time_left), 0);
      @(negedge frame_clk);
      Reset = 1'b0;
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
